// File: rtl/fetch_pc_unit.sv
// Program counter and instruction-fetch stage: fetches one word over a req/ack handshake,
// holds it for decode, and steps the PC (sequential, branch or jump) when it is consumed.
module fetch_pc_unit #(
    parameter int unsigned          WIDTH    = 32,
    parameter logic [WIDTH-1:0]     RESET_PC = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic [WIDTH-1:0] instr,
    output logic             instr_valid,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_offset,
    input  logic             jump,
    input  logic [25:0]      jump_index,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_HAVE = 2'd2;

    localparam logic [WIDTH-1:0] WORD_BYTES = 4;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] instr_q, instr_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] next_pc;

    assign pc_plus4 = pc_q + WORD_BYTES;

    // Jump keeps the top nibble of the sequential PC; jump wins over a taken branch.
    always_comb begin
        if (jump) begin
            next_pc = {pc_plus4[WIDTH-1:WIDTH-4], jump_index, 2'b00};
        end else if (branch_taken) begin
            next_pc = pc_plus4 + branch_offset;
        end else begin
            next_pc = pc_plus4;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
            end
            ST_REQ: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    valid_d = 1'b1;
                    state_d = ST_HAVE;
                end
            end
            ST_HAVE: begin
                if (!stall) begin
                    pc_d    = next_pc;
                    valid_d = 1'b0;
                    state_d = ST_REQ;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    assign imem_req    = (state_q == ST_REQ);
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign pc          = pc_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed scenarios with literal expectations, then randomized
// traffic with asynchronous resets, all tracked by a transaction-level model.
module tb_fetch_pc_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_offset;
    logic        jump;
    logic [25:0] jump_index;
    logic [31:0] pc;
    logic [31:0] pc_plus4;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    fetch_pc_unit #(
        .WIDTH    (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .jump          (jump),
        .jump_index    (jump_index),
        .pc            (pc),
        .pc_plus4      (pc_plus4)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a fetched word is either outstanding, held for decode, or there is a
    // one-cycle gap after reset in which nothing is requested.
    logic [31:0] m_pc    = 32'h0;
    logic [31:0] m_instr = 32'h0;
    bit          m_held  = 0;
    bit          m_gap   = 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc    = 32'h0;
            m_instr = 32'h0;
            m_held  = 0;
            m_gap   = 1;
        end else if (m_gap) begin
            m_gap = 0;
        end else if (!m_held) begin
            if (imem_ack) begin
                m_instr = imem_rdata;
                m_held  = 1;
            end
        end else if (!stall) begin
            logic [31:0] seq;
            seq = m_pc + 32'd4;
            if (jump)              m_pc = {seq[31:28], jump_index, 2'b00};
            else if (branch_taken) m_pc = seq + branch_offset;
            else                   m_pc = seq;
            m_held = 0;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_req",      imem_req,    {31'b0, !m_gap && !m_held});
            check("cyc_addr",     imem_addr,   m_pc);
            check("cyc_pc",       pc,          m_pc);
            check("cyc_pc_plus4", pc_plus4,    m_pc + 32'd4);
            check("cyc_valid",    instr_valid, {31'b0, m_held});
            check("cyc_instr",    instr,       m_instr);
        end
    end

    // Entered at a falling edge in the request phase; leaves at a falling edge holding data.
    task automatic fetch(input int waits, input logic [31:0] data, input logic [31:0] addr);
        for (int i = 0; i < waits; i++) begin
            imem_ack   = 0;
            imem_rdata = $urandom;
            check("wait_req",  imem_req,  32'd1);
            check("wait_addr", imem_addr, addr);
            @(negedge clk);
        end
        check("ack_req",  imem_req,  32'd1);
        check("ack_addr", imem_addr, addr);
        imem_ack   = 1;
        imem_rdata = data;
        @(negedge clk);
        imem_ack   = 0;
        imem_rdata = $urandom;
        check("have_valid", instr_valid, 32'd1);
        check("have_instr", instr,       data);
        check("have_req",   imem_req,    32'd0);
    endtask

    task automatic consume(input int stalls, input logic j, input logic br,
                           input logic [31:0] off, input logic [25:0] idx,
                           input logic [31:0] data, input logic [31:0] cur_pc);
        jump          = j;
        branch_taken  = br;
        branch_offset = off;
        jump_index    = idx;
        for (int i = 0; i < stalls; i++) begin
            stall = 1;
            @(negedge clk);
            check("stall_instr", instr,       data);
            check("stall_pc",    pc,          cur_pc);
            check("stall_valid", instr_valid, 32'd1);
        end
        stall = 0;
        @(negedge clk);
        jump         = 0;
        branch_taken = 0;
        check("cons_valid", instr_valid, 32'd0);
        check("cons_req",   imem_req,    32'd1);
    endtask

    initial begin
        rst_n         = 1;
        imem_ack      = 0;
        imem_rdata    = 0;
        stall         = 0;
        branch_taken  = 0;
        branch_offset = 0;
        jump          = 0;
        jump_index    = 0;
        #1 rst_n = 0;
        cmp_en = 1;
        repeat (3) @(negedge clk);
        check("rst_pc",    pc,          32'h0);
        check("rst_req",   imem_req,    32'd0);
        check("rst_valid", instr_valid, 32'd0);
        check("rst_instr", instr,       32'h0);
        rst_n = 1;
        check("idle_req", imem_req, 32'd0);
        @(negedge clk);
        check("first_req",  imem_req,  32'd1);
        check("first_addr", imem_addr, 32'h0);

        // Sequential fetches 0, 4, 8, 0xC
        for (int i = 0; i < 4; i++) begin
            logic [31:0] d;
            d = 32'hC0DE_0000 + i;
            check("seq_pc", pc, 32'(i * 4));
            fetch(0, d, 32'(i * 4));
            consume(0, 0, 0, 32'h0, 26'h0, d, 32'(i * 4));
        end
        check("seq_pc_end", pc, 32'h10);

        fetch(3, 32'h1234_5678, 32'h10);
        consume(4, 0, 0, 32'h0, 26'h0, 32'h1234_5678, 32'h10);
        check("stall_adv", pc, 32'h14);

        fetch(1, 32'h0800_0040, 32'h14);
        consume(0, 1, 0, 32'h0, 26'h40, 32'h0800_0040, 32'h14);
        check("jump_100", pc, 32'h100);

        fetch(0, 32'h1000_FFFC, 32'h100);
        consume(1, 0, 1, 32'hFFFF_FFF0, 26'h0, 32'h1000_FFFC, 32'h100);
        check("branch_back", pc, 32'hF4);

        fetch(0, 32'h0800_0040, 32'hF4);
        consume(0, 1, 0, 32'h0, 26'h40, 32'h0800_0040, 32'hF4);
        fetch(2, 32'h1000_0010, 32'h100);
        consume(0, 0, 1, 32'h40, 26'h0, 32'h1000_0010, 32'h100);
        check("branch_fwd", pc, 32'h144);

        fetch(0, 32'hAAAA_0001, 32'h144);
        consume(0, 0, 1, 32'h0FFF_FEB8, 26'h0, 32'hAAAA_0001, 32'h144);
        check("branch_far", pc, 32'h1000_0000);

        fetch(0, 32'h0C00_0040, 32'h1000_0000);
        consume(0, 1, 1, 32'h0000_0800, 26'h40, 32'h0C00_0040, 32'h1000_0000);
        check("jump_prio", pc, 32'h1000_0100);

        fetch(0, 32'hAAAA_0002, 32'h1000_0100);
        consume(0, 0, 1, 32'hEFFF_FEF8, 26'h0, 32'hAAAA_0002, 32'h1000_0100);
        check("wrap_pc",     pc,       32'hFFFF_FFFC);
        check("wrap_plus4",  pc_plus4, 32'h0);
        fetch(0, 32'hAAAA_0003, 32'hFFFF_FFFC);
        consume(0, 0, 0, 32'h0, 26'h0, 32'hAAAA_0003, 32'hFFFF_FFFC);
        check("wrap_next", pc, 32'h0);

        // Reset in the middle of a fetch, with an ack arriving during reset
        fetch(0, 32'hAAAA_0004, 32'h0);
        consume(0, 0, 0, 32'h0, 26'h0, 32'hAAAA_0004, 32'h0);
        check("pre_rst_pc", pc, 32'h4);
        imem_ack = 0;
        #2 rst_n = 0;
        #1;
        check("arst_pc",    pc,          32'h0);
        check("arst_valid", instr_valid, 32'd0);
        check("arst_req",   imem_req,    32'd0);
        imem_ack   = 1;
        imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        check("arst_idle_req", imem_req, 32'd0);
        @(negedge clk);
        check("arst_fresh_req",   imem_req,    32'd1);
        check("arst_fresh_addr",  imem_addr,   32'h0);
        check("arst_fresh_valid", instr_valid, 32'd0);
        imem_ack = 0;

        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            imem_ack      = ($urandom_range(0, 2) != 0);
            imem_rdata    = $urandom;
            stall         = ($urandom_range(0, 3) == 0);
            branch_taken  = ($urandom_range(0, 1) == 1);
            jump          = ($urandom_range(0, 3) == 0);
            branch_offset = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00} ^ {$urandom_range(0, 1) == 1, 31'b0};
            jump_index    = 26'($urandom);
            if ($urandom_range(0, 59) == 0) begin
                #2 rst_n = 0;
                #1;
                check("rnd_rst_pc",  pc,       32'h0);
                check("rnd_rst_req", imem_req, 32'd0);
                @(negedge clk);
                #2 rst_n = 1;
            end
        end

        @(negedge clk);
        cmp_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Program-counter and instruction-fetch stage of the MIPS CPU. It holds the PC, issues word fetches to instruction memory over a req/ack handshake, and presents the fetched instruction to decode. When decode consumes an instruction, the block computes the next PC. The next PC is one of:
- sequential PC+4;
- a branch target built from the word-aligned offset produced by `shift2`;
- a J-type jump target.

## Interface
Parameters:
- `WIDTH`, 32, datapath/address width (only 32 is supported).
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset (must be word aligned).

Ports:
- `clk`  in  1  single clock, all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_addr`  out  32  fetch address (= `pc`).
- `imem_ack`  in  1  memory returns `imem_rdata` this cycle.
- `imem_rdata`  in  32  instruction word.
- `instr`  out  32  registered instruction for decode.
- `instr_valid`  out  1  `instr` is valid and awaiting consumption.
- `stall`  in  1  decode/hazard unit holds the current instruction.
- `branch_taken`  in  1  take the branch for the current instruction.
- `branch_offset`  in  32  sign-extended immediate already shifted left 2 (output of `shift2`).
- `jump`  in  1  current instruction is J/JAL.
- `jump_index`  in  26  instruction bits [25:0].
- `pc`  out  32  address of current/pending instruction.
- `pc_plus4`  out  32  `pc + 4` (combinational from `pc`), used for link register.

## Operation
- FSM states: IDLE, REQ, HAVE.
- IDLE:
  - Entered on reset.
  - Outputs quiet.
  - Always moves to REQ on the next edge.
- REQ:
  - `imem_req`=1 and `imem_addr`=`pc`, both held stable until ack.
  - On `imem_ack`: `instr`<=`imem_rdata`, `instr_valid`<=1, go to HAVE.
  - `stall`, `branch_taken` and `jump` are ignored in REQ.
- HAVE:
  - `imem_req`=0 and `instr_valid`=1.
  - If `stall`=1: hold all state; `instr` does not change.
  - If `stall`=0, the instruction is consumed on this edge: `pc`<=next_pc, `instr_valid`<=0, go to REQ.
- next_pc, evaluated only in HAVE with `stall`=0:
  - If `jump`: {`pc_plus4`[31:28], `jump_index`, 2'b00}.
  - Else if `branch_taken`: `pc_plus4` + `branch_offset`, mod 2^32.
  - Else: `pc_plus4`.
  - `jump` has priority when `jump` and `branch_taken` are both 1.
- Arithmetic:
  - All adds are 32-bit unsigned wrap; no overflow flag.
  - 32'hFFFF_FFFC + 4 = 32'h0000_0000.
  - A negative `branch_offset` (two's complement) moves backwards.
- There is no branch delay slot: the instruction after a taken branch/jump is never fetched.

## Timing
- Reset (async assert, any state) forces:
  - state=IDLE, `pc`=`RESET_PC`, `instr`=0;
  - `instr_valid`=0, `imem_req`=0, `imem_addr`=`RESET_PC`.
- Reset release: IDLE for exactly one cycle, then REQ.
- Fetch latency:
  - `instr_valid` rises on the edge where `imem_ack` is sampled high.
  - `imem_ack` may be high in the first REQ cycle, giving a best case of 1 cycle REQ.
  - Any number of wait cycles is allowed.
- Throughput: at best one instruction per 2 cycles (REQ + HAVE).
- Redirect: the new `pc` is visible, and `imem_req` is asserted, in the cycle after consumption.
- Reset asserted mid-REQ or mid-HAVE:
  - the pending fetch is abandoned;
  - a late `imem_ack` is ignored while in IDLE.
- `imem_ack` sampled outside REQ has no effect.

## Test plan
- Reset/sequential:
  - Stimulus: `RESET_PC`=0, ack every REQ cycle, no stall/branch.
  - Required: `pc` sequence 0, 4, 8, 0xC; `instr_valid` pattern 0 (IDLE), then 1,0,1,0…; `instr` equals `imem_rdata` returned for each address.
- Wait states and stall:
  - Stimulus: ack delayed 3 cycles, then `stall`=1 for 4 cycles in HAVE.
  - Required: `imem_addr` stable for all 4 REQ cycles; `instr`/`pc` unchanged during stall; advance on the first `stall`=0 edge.
- Branch:
  - Backward: at `pc`=0x100, `branch_taken`=1, `branch_offset`=0xFFFF_FFF0 → next `pc`=0xF4.
  - Forward: `branch_offset`=0x40 at `pc`=0x100 → 0x144.
- Jump priority:
  - Stimulus: at `pc`=0x1000_0000, `jump`=1, `branch_taken`=1, `jump_index`=0x0000040.
  - Required: next `pc`=0x1000_0100.
- Wrap:
  - Stimulus: `pc`=0xFFFF_FFFC, sequential.
  - Required: next `pc`=0x0000_0000 and `pc_plus4` shows 0 beforehand.
- Async reset mid-fetch:
  - Stimulus: assert `rst_n`=0 in REQ before ack, ack arrives while in reset.
  - Required: immediately `pc`=`RESET_PC`, `instr_valid`=0, `imem_req`=0; after release, one IDLE cycle then a fresh REQ to `RESET_PC`.
